// File: rtl/ica_centering.sv
// Frame-based mean removal for a two-channel ICA front end: buffers N pairs, computes floor means, emits centred pairs.
// Define ICA_CENTER_SAT_EN to saturate the centred difference; otherwise it wraps to DATA_WIDTH bits.
module ica_centering #(
    parameter int DATA_WIDTH = 16,
    parameter int LOG2_FRAME = 6
) (
    input  logic                  clk,
    input  logic                  nreset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_x1,
    input  logic [DATA_WIDTH-1:0] in_x2,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_x1,
    output logic [DATA_WIDTH-1:0] out_x2,
    output logic                  out_last,
    output logic [DATA_WIDTH-1:0] mean_x1,
    output logic [DATA_WIDTH-1:0] mean_x2,
    output logic                  done_center
);
    localparam int N  = 1 << LOG2_FRAME;
    localparam int DW = DATA_WIDTH;
    localparam int AW = DATA_WIDTH + LOG2_FRAME;
    localparam logic [LOG2_FRAME-1:0] LAST_IDX = LOG2_FRAME'(N - 1);

    typedef enum logic [1:0] {LOAD, MEAN, EMIT, DONE} state_e;

    state_e                 state_q, state_d;
    logic [LOG2_FRAME-1:0]  wr_idx_q, wr_idx_d;
    logic [LOG2_FRAME-1:0]  rd_idx_q, rd_idx_d;
    logic signed [AW-1:0]   acc1_q, acc1_d, acc2_q, acc2_d;
    logic [DW-1:0]          mean1_q, mean1_d, mean2_q, mean2_d;
    logic [DW-1:0]          out1_q, out1_d, out2_q, out2_d;
    logic                   ovalid_q, ovalid_d, olast_q, olast_d;
    logic                   ready_q, ready_d, done_q, done_d;
    logic [2*DW-1:0]        mem [N];
    logic [2*DW-1:0]        rd_data_q;

    logic          accept, out_fire, load_out;
    logic [DW-1:0] mean_now1, mean_now2, mean_use1, mean_use2;

    assign accept   = in_valid & ready_q;
    assign out_fire = ovalid_q & out_ready;

    function automatic logic [DW-1:0] center(input logic [DW-1:0] x, input logic [DW-1:0] m);
        logic signed [DW:0] diff;
        logic [DW-1:0]      res;
        diff = $signed({x[DW-1], x}) - $signed({m[DW-1], m});
        res  = diff[DW-1:0];
`ifdef ICA_CENTER_SAT_EN
        if (diff[DW] != diff[DW-1])
            res = diff[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
`endif
        return res;
    endfunction

    // Buffer: synchronous write, registered read; rd_data_q always mirrors mem[rd_idx_q]
    always_ff @(posedge clk) begin
        if (accept)
            mem[wr_idx_q] <= {in_x1, in_x2};
        rd_data_q <= mem[rd_idx_d];
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q  <= LOAD;
            wr_idx_q <= '0;
            rd_idx_q <= '0;
            acc1_q   <= '0;
            acc2_q   <= '0;
            mean1_q  <= '0;
            mean2_q  <= '0;
            out1_q   <= '0;
            out2_q   <= '0;
            ovalid_q <= 1'b0;
            olast_q  <= 1'b0;
            ready_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_idx_q <= wr_idx_d;
            rd_idx_q <= rd_idx_d;
            acc1_q   <= acc1_d;
            acc2_q   <= acc2_d;
            mean1_q  <= mean1_d;
            mean2_q  <= mean2_d;
            out1_q   <= out1_d;
            out2_q   <= out2_d;
            ovalid_q <= ovalid_d;
            olast_q  <= olast_d;
            ready_q  <= ready_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            LOAD:    if (accept && wr_idx_q == LAST_IDX) state_d = MEAN;
            MEAN:    state_d = EMIT;
            EMIT:    if (out_fire && olast_q) state_d = DONE;
            default: state_d = LOAD;
        endcase
    end

    // The first pair is centred in MEAN itself, so it uses the mean being computed rather than the stale register
    assign mean_now1 = DW'(acc1_q >>> LOG2_FRAME);
    assign mean_now2 = DW'(acc2_q >>> LOG2_FRAME);
    assign mean_use1 = (state_q == MEAN) ? mean_now1 : mean1_q;
    assign mean_use2 = (state_q == MEAN) ? mean_now2 : mean2_q;
    assign load_out  = (state_q == MEAN) || (state_q == EMIT && out_fire && !olast_q);

    always_comb begin
        wr_idx_d = wr_idx_q;
        rd_idx_d = rd_idx_q;
        acc1_d   = acc1_q;
        acc2_d   = acc2_q;
        mean1_d  = mean1_q;
        mean2_d  = mean2_q;
        out1_d   = out1_q;
        out2_d   = out2_q;
        ovalid_d = ovalid_q;
        olast_d  = olast_q;
        if (accept) begin
            wr_idx_d = wr_idx_q + 1'b1;
            acc1_d   = acc1_q + {{LOG2_FRAME{in_x1[DW-1]}}, in_x1};
            acc2_d   = acc2_q + {{LOG2_FRAME{in_x2[DW-1]}}, in_x2};
        end
        if (state_q == MEAN) begin
            mean1_d = mean_now1;
            mean2_d = mean_now2;
            acc1_d  = '0;
            acc2_d  = '0;
        end
        if (load_out) begin
            out1_d   = center(rd_data_q[2*DW-1:DW], mean_use1);
            out2_d   = center(rd_data_q[DW-1:0], mean_use2);
            ovalid_d = 1'b1;
            olast_d  = (rd_idx_q == LAST_IDX);
            rd_idx_d = rd_idx_q + 1'b1;
        end
        if (state_q == EMIT && out_fire && olast_q) begin
            ovalid_d = 1'b0;
            olast_d  = 1'b0;
        end
        if (state_q == DONE) begin
            wr_idx_d = '0;
            rd_idx_d = '0;
        end
    end

    assign ready_d = (state_d == LOAD);
    assign done_d  = (state_d == DONE);

    assign in_ready    = ready_q;
    assign out_valid   = ovalid_q;
    assign out_last    = olast_q;
    assign out_x1      = out1_q;
    assign out_x2      = out2_q;
    assign mean_x1     = mean1_q;
    assign mean_x2     = mean2_q;
    assign done_center = done_q;
endmodule

// File: doc/ica_centering.md
ICA_CENTERING -- requirements
Module: ica_centering

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, signed sample width per channel.
REQ-002 SHALL have parameter LOG2_FRAME, default 6, frame length N = 2**LOG2_FRAME samples.
REQ-003 SHALL have one clock and an asynchronous active-low reset: clk  input  1  rising-edge clock.
REQ-004 nreset  input  1  asynchronous active-low reset.
REQ-005 in_valid  input  1  upstream sample pair valid.
REQ-006 in_ready  output  1  block accepts a sample pair.
REQ-007 in_x1, in_x2  input  DATA_WIDTH each  signed mixed-signal channels.
REQ-008 out_valid  output  1  centred sample pair valid, feeding the ICA core.
REQ-009 out_ready  input  1  downstream accepts the pair.
REQ-010 out_x1, out_x2  output  DATA_WIDTH each  signed centred samples.
REQ-011 out_last  output  1  marks the Nth output of a frame.
REQ-012 mean_x1, mean_x2  output  DATA_WIDTH each  signed frame means, valid from first out_valid of a frame until next frame's mean update.
REQ-013 done_center  output  1  one-cycle pulse after the last output of a frame is accepted.

Function
REQ-014 SHALL implement FSM states LOAD, MEAN, EMIT, DONE.
REQ-015 LOAD: in_ready=1; each cycle with in_valid=1 writes the pair to an internal N-deep buffer at write index and adds both samples to signed accumulators of width DATA_WIDTH+LOG2_FRAME.
REQ-016 LOAD -> MEAN on the cycle the Nth pair is accepted; in_ready SHALL be 0 in MEAN, EMIT, DONE.
REQ-017 MEAN: single cycle; mean = accumulator arithmetic-shifted right by LOG2_FRAME (floor toward negative infinity), registered into mean_x1/mean_x2; accumulators cleared.
REQ-018 MEAN -> EMIT unconditionally; first out_valid asserts the cycle after MEAN, i.e. 2 cycles after the Nth input handshake.
REQ-019 EMIT: out_x = buffer[read index] - mean per channel, computed at DATA_WIDTH+1 bits then reduced per REQ-029/030.
REQ-020 Output pair, out_valid, out_last SHALL be registered and held stable while out_valid=1 and out_ready=0.
REQ-021 Read index advances only on out_valid & out_ready; outputs emitted in input order, no gaps imposed by the block (back-to-back when out_ready=1).
REQ-022 out_last=1 only with the Nth output; its handshake moves EMIT -> DONE.
REQ-023 DONE: done_center=1 for exactly one cycle, out_valid=0; DONE -> LOAD, write/read indices wrap to 0.
REQ-024 in_valid while in_ready=0 SHALL be ignored (no data loss claim; upstream holds).
REQ-025 Buffer SHALL be N entries x 2*DATA_WIDTH, single write port, single read port.

Reset
REQ-026 nreset low SHALL asynchronously force state LOAD, indices 0, accumulators 0.
REQ-027 Reset values: in_ready=0 during reset then 1 in LOAD, out_valid=0, out_last=0, done_center=0, out_x1/out_x2=0, mean_x1/mean_x2=0.
REQ-028 Reset mid-frame SHALL discard partial frame entirely; buffer contents need not be cleared.

Configuration
REQ-029 Macro ICA_CENTER_SAT_EN defined: difference saturates to [-2**(DATA_WIDTH-1), 2**(DATA_WIDTH-1)-1].
REQ-030 Macro ICA_CENTER_SAT_EN undefined: difference truncated to DATA_WIDTH LSBs (two's-complement wrap); no other behaviour changes.

Verification
REQ-031 Constant frame: 64 pairs x1=100, x2=-50 -> mean_x1=100, mean_x2=-50, all 64 outputs 0/0, out_last on 64th, done_center one pulse.
REQ-032 Ramp: x1=k, x2=-k, k=0..63 -> mean_x1=31, mean_x2=-32 (floor), out_x1=-31..32, out_x2=32..-31; first out_valid 2 cycles after 64th input handshake.
REQ-033 Backpressure: out_ready toggled pseudo-randomly during EMIT -> outputs held stable when stalled, 64 outputs in order, in_ready=0 throughout EMIT.
REQ-034 Saturation: x1 alternating 32767, -32768 (32767 first) -> mean_x1=-1; with ICA_CENTER_SAT_EN out_x1 for 32767 inputs =32767; without, =-32768.
REQ-035 Reset mid-frame: assert nreset after 20 inputs, release, feed 64 pairs of x1=x2=7 -> means 7/7, outputs all 0, no residue from aborted frame.
REQ-036 Two consecutive frames (constants 10 then -10) -> means update at second MEAN only, done_center pulses twice.
